univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/usr_pkg.sv | 11 +
 rtl/usr_shift_cnt.sv | 34 +++
 rtl/univ_shift_reg.sv | 83 ++++++++
 tb/tb_univ_shift_reg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operating mode encoding.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/usr_shift_cnt.sv
// Direction-agnostic shift counter; pulses done for one cycle after WIDTH shifts.
module usr_shift_cnt #(
  parameter int WIDTH = 4,
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (shift) begin
      // wrap and pulse on the shift that completes the word
      if (cnt == LAST) begin
        cnt  <= '0;
        done <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load.
// Optional rotate on shifts when USR_ROTATE_EN is defined; rot is ignored otherwise.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pload,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  mode_t            mode_e;
  logic             fill_r;
  logic             fill_l;
  logic [WIDTH-1:0] q_nxt;
  logic             do_shift;
  logic             do_clear;

  assign mode_e = mode_t'(mode);

`ifdef USR_ROTATE_EN
  assign fill_r = rot ? q[0]       : sin_r;
  assign fill_l = rot ? q[WIDTH-1] : sin_l;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign fill_r     = sin_r;
  assign fill_l     = sin_l;
`endif

  always_comb begin
    q_nxt    = q;
    do_shift = 1'b0;
    do_clear = 1'b0;
    if (en) begin
      unique case (mode_e)
        MODE_SHR: begin
          q_nxt    = {fill_r, q[WIDTH-1:1]};
          do_shift = 1'b1;
        end
        MODE_SHL: begin
          q_nxt    = {q[WIDTH-2:0], fill_l};
          do_shift = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt    = pload;
          do_clear = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_nxt;
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  usr_shift_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .shift (do_shift),
    .clear (do_clear),
    .cnt   (shift_cnt),
    .done  (word_done)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4): vector table plus hand-written sequences.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst, en, sin_r, sin_l, rot;
  logic [1:0] mode;
  logic [3:0] pload;
  logic [3:0] q;
  logic       sout_r, sout_l, word_done;
  logic [1:0] shift_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .pload     (pload),
    .rot       (rot),
    .q         (q),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .shift_cnt (shift_cnt),
    .word_done (word_done)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sr;
    logic       sl;
    logic [3:0] pload;
    logic [3:0] q;
    logic [1:0] cnt;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic sr,
                     input logic sl, input logic [3:0] pl, input logic [3:0] eq,
                     input logic [1:0] ec, input logic ed);
    vecs.push_back('{r, e, m, sr, sl, pl, eq, ec, ed});
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic sr,
                       input logic sl, input logic ro, input logic [3:0] pl);
    @(negedge clk);
    rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; rot = ro; pload = pl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int idx, input logic [3:0] eq,
                           input logic [1:0] ec, input logic ed);
    chk({tag, "_q"}, idx, 32'(q), 32'(eq));
    chk({tag, "_cnt"}, idx, 32'(shift_cnt), 32'(ec));
    chk({tag, "_done"}, idx, 32'(word_done), 32'(ed));
    chk({tag, "_sout_r"}, idx, 32'(sout_r), 32'(eq[0]));
    chk({tag, "_sout_l"}, idx, 32'(sout_l), 32'(eq[3]));
  endtask

  int pulses;
  int first_pulse;
  int last_pulse;
  logic [3:0] rot_exp;

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0; pload = 4'h0;

    //   rst en mode  sr sl pload   q      cnt done
    add(1, 1, 2'b11, 0, 0, 4'hF, 4'b0000, 0, 0);  // reset beats load
    add(0, 1, 2'b11, 0, 0, 4'hB, 4'b1011, 0, 0);
    add(0, 1, 2'b01, 0, 0, 4'h0, 4'b0101, 1, 0);
    add(0, 1, 2'b01, 0, 0, 4'h0, 4'b0010, 2, 0);
    add(0, 1, 2'b01, 0, 0, 4'h0, 4'b0001, 3, 0);
    add(0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 0, 1);
    add(0, 1, 2'b00, 0, 0, 4'h0, 4'b0000, 0, 0);
    add(0, 1, 2'b10, 0, 1, 4'h0, 4'b0001, 1, 0);
    add(0, 1, 2'b10, 0, 0, 4'h0, 4'b0010, 2, 0);
    add(0, 1, 2'b10, 0, 1, 4'h0, 4'b0101, 3, 0);
    add(0, 1, 2'b10, 0, 1, 4'h0, 4'b1011, 0, 1);
    add(0, 1, 2'b00, 0, 0, 4'h0, 4'b1011, 0, 0);
    add(0, 1, 2'b01, 1, 0, 4'h0, 4'b1101, 1, 0);
    add(0, 1, 2'b10, 0, 0, 4'h0, 4'b1010, 2, 0);  // direction change keeps count
    add(0, 0, 2'b01, 1, 1, 4'h0, 4'b1010, 2, 0);
    add(0, 0, 2'b10, 1, 1, 4'hF, 4'b1010, 2, 0);
    add(0, 0, 2'b11, 1, 1, 4'hF, 4'b1010, 2, 0);
    add(0, 1, 2'b10, 0, 1, 4'h0, 4'b0101, 3, 0);
    add(0, 1, 2'b01, 0, 0, 4'h0, 4'b0010, 0, 1);
    add(0, 0, 2'b01, 0, 0, 4'h0, 4'b0010, 0, 0);
    add(0, 1, 2'b10, 0, 1, 4'h0, 4'b0101, 1, 0);
    add(0, 1, 2'b10, 0, 1, 4'h0, 4'b1011, 2, 0);
    add(1, 1, 2'b01, 1, 0, 4'h0, 4'b0000, 0, 0);  // reset mid-word
    add(0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 1, 0);
    add(0, 1, 2'b01, 1, 0, 4'h0, 4'b1100, 2, 0);
    add(0, 1, 2'b01, 1, 0, 4'h0, 4'b1110, 3, 0);
    add(0, 1, 2'b01, 1, 0, 4'h0, 4'b1111, 0, 1);
    add(0, 1, 2'b01, 0, 0, 4'h0, 4'b0111, 1, 0);
    add(0, 1, 2'b11, 0, 0, 4'h6, 4'b0110, 0, 0);  // load mid-word clears count

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].sr, vecs[i].sl, 1'b0, vecs[i].pload);
      chk_state("vec", i, vecs[i].q, vecs[i].cnt, vecs[i].done);
    end

    // 8 continuous left shifts: two pulses, 4 cycles apart, no gap
    drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'h0);
    pulses = 0; first_pulse = -1; last_pulse = -1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 4'h0);
      chk("cont_cnt", i, 32'(shift_cnt), 32'(i % 4));
      if (word_done) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        last_pulse = i;
      end
    end
    chk("cont_pulses", 0, 32'(pulses), 32'd2);
    chk("cont_first", 0, 32'(first_pulse), 32'd4);
    chk("cont_spacing", 0, 32'(last_pulse - first_pulse), 32'd4);
    chk("cont_q", 0, 32'(q), 32'hF);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("cont_after", 0, 32'(word_done), 32'd0);

    // rotate-left from 1000 with sin_l=0
    drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'h8);
    pulses = 0;
    rot_exp = 4'b1000;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 4'h0);
`ifdef USR_ROTATE_EN
      rot_exp = {rot_exp[2:0], rot_exp[3]};
`else
      rot_exp = {rot_exp[2:0], 1'b0};
`endif
      chk("rot_q", i, 32'(q), 32'(rot_exp));
      if (word_done) pulses++;
    end
    chk("rot_pulses", 0, 32'(pulses), 32'd1);
    chk("rot_done_last", 0, 32'(word_done), 32'd1);

    // rotate-right from 0001 with sin_r=0
    drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'h1);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 4'h0);
`ifdef USR_ROTATE_EN
    chk("rotr_q", 0, 32'(q), 32'h8);
`else
    chk("rotr_q", 0, 32'(q), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
